// File: rtl/alu_sum_arbiter.sv
// Round-robin arbiter sharing one external 32-bit adder between two requesters.
// Operands are latched on accept; the registered sum is held until the consumer takes it.
module alu_sum_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_srcA,
  input  logic [WIDTH-1:0] req0_srcB,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_srcA,
  input  logic [WIDTH-1:0] req1_srcB,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant0, grant1;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state, grant and handshake logic
  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    cnt_d        = cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    // On a tie the requester that was not served last wins
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          req0_ready = 1'b1;
          opa_d      = req0_srcA;
          opb_d      = req0_srcB;
          grant_id_d = 1'b0;
          state_d    = EXEC;
        end else if (grant1) begin
          req1_ready = 1'b1;
          opa_d      = req1_srcA;
          opb_d      = req1_srcB;
          grant_id_d = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_res;
        rsp_id_d    = grant_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = rsp_id_q;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign alu_srcA  = opa_q;
  assign alu_srcB  = opb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign op_count  = cnt_q;

endmodule
